// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter slot.
// Register indices are slot word addresses; DATA_BITS is the serial payload width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [4:0] REG_STATUS = 5'd0;
    localparam logic [4:0] REG_DVSR   = 5'd1;
    localparam logic [4:0] REG_TXDATA = 5'd2;
    localparam logic [4:0] REG_CLR    = 5'd3;
    localparam logic [4:0] REG_CTRL   = 5'd4;

    localparam int DATA_BITS = 8;

    // Parity over the payload; odd selects inversion of the even-parity bit.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_core_fifo.sv
// Synchronous FIFO whose head word is read straight out of the storage registers.
// A write into a full FIFO is honoured only when a read is popping in the same cycle.
module fifo_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_en_s;
    logic              rd_en_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == {(ADDR_W + 1){1'b0}});
    assign rd_data_o = mem_q[rd_ptr_q];

    // Reads of an empty FIFO are ignored; writes to a full one need a concurrent pop.
    assign rd_en_s = rd_i & ~empty_o;
    assign wr_en_s = wr_i & (~full_o | rd_i);

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {(ADDR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until pointers mark them valid.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx_core.sv
// Buffered UART transmitter on one MMIO slot: register decode, baud timer, TX FSM.
// Optional build macro UART_TX_PARITY_EN adds a PARITY bit slot and CTRL register at index 4.
module mmio_uart_tx_core
    import uart_pkg::*;
#(
    parameter int FIFO_ADDR_W = 4,
    parameter int DVSR_W      = 16,
    parameter int DVSR_RST    = 867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx
);

    localparam logic [DVSR_W-1:0] CNT_ZERO = {DVSR_W{1'b0}};
    localparam logic [DVSR_W-1:0] CNT_ONE  = DVSR_W'(1);

    logic              wr_en_s;
    logic              push_s;
    logic              push_ok_s;
    logic              clr_s;
    logic              dvsr_wr_s;
    logic              pop_s;
    logic              tick_s;
    logic              busy_s;
    logic              start_frame_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [7:0]        fifo_dout_s;
    logic              unused_s;

    logic [DVSR_W-1:0] dvsr_q;
    logic              ovf_q;
    tx_state_t         state_q, state_d;
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [DVSR_W-1:0] dvsr_frame_q, dvsr_frame_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              ctrl_wr_s;
    logic [1:0]        ctrl_q;
    logic              par_en_frame_q, par_en_frame_d;
    logic              par_bit_q, par_bit_d;
`endif

    // The read strobe has no side effects and wide write data is only partly decoded.
    assign unused_s = ^{read, wr_data};

    assign wr_en_s   = cs & write;
    assign push_s    = wr_en_s & (addr == REG_TXDATA);
    assign clr_s     = wr_en_s & (addr == REG_CLR);
    assign dvsr_wr_s = wr_en_s & (addr == REG_DVSR);
`ifdef UART_TX_PARITY_EN
    assign ctrl_wr_s = wr_en_s & (addr == REG_CTRL);
`endif

    // A push to a full FIFO still lands when the FSM pops in the same cycle.
    assign push_ok_s = push_s & (~fifo_full_s | pop_s);

    assign busy_s = (state_q != IDLE);
    assign tick_s = (cnt_q == dvsr_frame_q);
    assign start_frame_s = ~fifo_empty_s &
                           ((state_q == IDLE) | ((state_q == STOP) & tick_s));
    assign tx = tx_q;

    fifo_sync #(
        .DATA_W (8),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_i      (push_ok_s),
        .wr_data_i (wr_data[7:0]),
        .rd_i      (pop_s),
        .rd_data_o (fifo_dout_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    // Firmware-visible configuration and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvsr_q <= DVSR_W'(DVSR_RST);
            ovf_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            ctrl_q <= 2'b00;
`endif
        end else begin
            if (dvsr_wr_s) begin
                dvsr_q <= wr_data[DVSR_W-1:0];
            end
            if (clr_s) begin
                ovf_q <= 1'b0;
            end else if (push_s & ~push_ok_s) begin
                ovf_q <= 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            if (ctrl_wr_s) begin
                ctrl_q <= wr_data[1:0];
            end
`endif
        end
    end

    // Next-state logic for the bit timer, frame sequencer and shift register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dvsr_frame_d = dvsr_frame_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        pop_s        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_frame_d = par_en_frame_q;
        par_bit_d      = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
            end
            START: begin
                if (tick_s) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (tick_s) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_frame_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (tick_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase

        // Frame start overrides the IDLE/STOP exits so back-to-back frames have no gap.
        if (start_frame_s) begin
            pop_s        = 1'b1;
            shift_d      = fifo_dout_s;
            dvsr_frame_d = dvsr_q;
            cnt_d        = CNT_ZERO;
            bit_idx_d    = 3'd0;
            state_d      = START;
`ifdef UART_TX_PARITY_EN
            par_en_frame_d = ctrl_q[1];
            par_bit_d      = parity_bit(fifo_dout_s, ctrl_q[0]);
`endif
        end else begin
            pop_s = 1'b0;
        end
    end

    // Line level is derived from the upcoming state so tx itself is a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_bit_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // Transmitter state registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            dvsr_frame_q <= CNT_ZERO;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_frame_q <= 1'b0;
            par_bit_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dvsr_frame_q <= dvsr_frame_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_en_frame_q <= par_en_frame_d;
            par_bit_q      <= par_bit_d;
`endif
        end
    end

    // Register read mux, combinational from addr.
    always_comb begin
        rd_data = 32'h0000_0000;
        case (addr)
            REG_STATUS: rd_data = {28'h000_0000, ovf_q, busy_s, fifo_full_s, fifo_empty_s};
            REG_DVSR:   rd_data = {{(32 - DVSR_W){1'b0}}, dvsr_q};
`ifdef UART_TX_PARITY_EN
            REG_CTRL:   rd_data = {30'h0000_0000, ctrl_q};
`endif
            default:    rd_data = 32'h0000_0000;
        endcase
    end

endmodule
